uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx` serializer of the watch/stopwatch UART subsystem between two requesters: the RX→TX echo path (single bytes) and a status reporter that sends multi-byte packets such as "HH:MM:SS\r\n".
- Arbitration is round-robin at packet boundaries; a report packet holds the transmitter until its last byte.
- The block issues one start pulse per byte and tracks `tx_busy` to sequence bytes back-to-back.
- It sits between the TX FIFO / report generator and `uart_tx`, replacing the direct FIFO→`uart_tx` connection.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the echo/report requesters, the arbiter and uart_tx.
// The slave modport is the arbiter side; master is the requester/serializer side.
interface uart_tx_arbiter_if #(
    parameter int unsigned DATA_W = 8
);
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    logic              e_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_ready;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        grant;
    logic              abort;

    modport slave (
        input  e_valid, e_data, r_valid, r_data, r_last, tx_busy,
        output e_ready, r_ready, tx_start, tx_data, grant, abort
    );

    modport master (
        output e_valid, e_data, r_valid, r_data, r_last, tx_busy,
        input  e_ready, r_ready, tx_start, tx_data, grant, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between echo bytes and locked report packets.
// Optional mid-packet lock timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 100_000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_ECHO   = 2'b01;
    localparam logic [1:0] GNT_REPORT = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [1:0]        grant_q, grant_d;
    logic              tx_start_q, tx_start_d;
    logic              lock_q, lock_d;
    logic              last_rep_q, last_rep_d;
    logic              pick_e_c, pick_r_c;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
`endif

    // Winner selection; readies are held low while reset is asserted.
    always_comb begin
        pick_e_c = 1'b0;
        pick_r_c = 1'b0;
        if (rst && (state_q == ST_IDLE) && !bus.tx_busy) begin
            if (lock_q) begin
                pick_r_c = bus.r_valid;
            end else if (bus.e_valid && bus.r_valid) begin
                pick_e_c = last_rep_q;
                pick_r_c = !last_rep_q;
            end else begin
                pick_e_c = bus.e_valid;
                pick_r_c = bus.r_valid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        tx_start_d = 1'b0;
        lock_d     = lock_q;
        last_rep_d = last_rep_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = '0;
        abort_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_e_c) begin
                    tx_data_d  = bus.e_data;
                    grant_d    = GNT_ECHO;
                    tx_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end else if (pick_r_c) begin
                    tx_data_d  = bus.r_data;
                    grant_d    = GNT_REPORT;
                    lock_d     = !bus.r_last;
                    tx_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // A report only counts as served once its last byte has gone out.
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                    if (grant_q == GNT_ECHO) begin
                        last_rep_d = 1'b0;
                    end else if (!lock_q) begin
                        last_rep_d = 1'b1;
                    end
                    if (!lock_q) begin
                        grant_d = GNT_NONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        // Stalled report packet: drop the lock and hand the next turn to echo.
        if ((state_q == ST_IDLE) && lock_q && !bus.r_valid) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                lock_d     = 1'b0;
                last_rep_d = 1'b1;
                grant_d    = GNT_NONE;
                abort_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            grant_q    <= GNT_NONE;
            tx_start_q <= 1'b0;
            lock_q     <= 1'b0;
            last_rep_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            lock_q     <= lock_d;
            last_rep_q <= last_rep_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign bus.abort = abort_q;
`else
    assign bus.abort = 1'b0;
`endif

    assign bus.e_ready  = pick_e_c;
    assign bus.r_ready  = pick_r_c;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant    = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of packet mixes plus hand-written
// latency, long-packet, busy-hold, stall/timeout and mid-frame reset sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned DW       = 8;
    localparam int unsigned TO       = 50;
    localparam int          BUSY_LEN = 10;

    typedef struct {
        logic       rep;
        logic [7:0] data;
        int         cyc;
    } acc_t;

    typedef struct {
        logic [1:0] grant;
        logic [7:0] data;
        int         cyc;
    } txe_t;

    typedef struct {
        int unsigned n_echo;
        int unsigned n_rep;
        logic [15:0] order;
        int unsigned n_tot;
        logic        single;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_W(DW)) bus ();

    uart_tx_arbiter #(
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] eq[$];
    logic [8:0] rq[$];
    acc_t       acc_q[$];
    txe_t       tx_q[$];
    acc_t       exp_q[$];

    int         cyc        = 0;
    int         n_tests    = 0;
    int         n_fail     = 0;
    int         excl_bad   = 0;
    int         grant_bad  = 0;
    int         abort_cnt  = 0;
    int         abort_cyc  = -1;
    logic [1:0] abort_grant = 2'b11;
    int         busy_cnt   = 0;
    logic       busy_force = 1'b0;
    logic       rep_open   = 1'b0;
    logic       e_took     = 1'b0;
    logic       r_took     = 1'b0;
    acc_t       mon_a;
    txe_t       mon_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_src();
        bus.e_valid = (eq.size() > 0);
        bus.e_data  = (eq.size() > 0) ? eq[0] : 8'h00;
        bus.r_valid = (rq.size() > 0);
        bus.r_data  = (rq.size() > 0) ? rq[0][7:0] : 8'h00;
        bus.r_last  = (rq.size() > 0) ? rq[0][8] : 1'b0;
    endtask

    // Requester sources, tx_busy model and output monitor share one timeline.
    initial begin
        bus.tx_busy = 1'b0;
        drive_src();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (e_took && eq.size() > 0) void'(eq.pop_front());
            if (r_took && rq.size() > 0) void'(rq.pop_front());
            e_took = 1'b0;
            r_took = 1'b0;
            drive_src();
            @(negedge clk);
            if (!rst) busy_cnt = 0;
            else if (bus.tx_start) busy_cnt = BUSY_LEN;
            else if (busy_cnt > 0) busy_cnt--;
            bus.tx_busy = busy_force || (busy_cnt > 0);
            #1;
            if (!rst) rep_open = 1'b0;
            if (bus.abort) begin
                abort_cnt++;
                abort_cyc   = cyc;
                abort_grant = bus.grant;
                rep_open    = 1'b0;
            end
            if (bus.e_ready && bus.r_ready) excl_bad++;
            if (rep_open && bus.grant != 2'b10) grant_bad++;
            if (bus.e_ready) begin
                mon_a.rep = 1'b0; mon_a.data = bus.e_data; mon_a.cyc = cyc;
                acc_q.push_back(mon_a);
                e_took = 1'b1;
            end
            if (bus.r_ready) begin
                mon_a.rep = 1'b1; mon_a.data = bus.r_data; mon_a.cyc = cyc;
                acc_q.push_back(mon_a);
                r_took   = 1'b1;
                rep_open = !bus.r_last;
            end
            if (bus.tx_start) begin
                mon_t.grant = bus.grant; mon_t.data = bus.tx_data; mon_t.cyc = cyc;
                tx_q.push_back(mon_t);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic exp_add(input logic rep, input logic [7:0] data);
        acc_t e;
        e.rep = rep; e.data = data; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_accepts(input int n);
        int k;
        k = 0;
        while (acc_q.size() < n && k < 3000) begin
            tick(1);
            k++;
        end
        tick(BUSY_LEN + 6);
        k = 0;
        while (bus.tx_busy && k < 3000) begin
            tick(1);
            k++;
        end
        tick(2);
    endtask

    task automatic check_seq(input string nm);
        logic [1:0] g;
        chk({nm, "_count"}, acc_q.size(), exp_q.size());
        chk({nm, "_starts"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            g = exp_q[i].rep ? 2'b10 : 2'b01;
            if (i < int'(acc_q.size())) begin
                chk($sformatf("%s_owner%0d", nm, i), acc_q[i].rep, exp_q[i].rep);
                chk($sformatf("%s_accdata%0d", nm, i), acc_q[i].data, exp_q[i].data);
            end
            if (i < int'(tx_q.size())) begin
                chk($sformatf("%s_grant%0d", nm, i), tx_q[i].grant, g);
                chk($sformatf("%s_txdata%0d", nm, i), tx_q[i].data, exp_q[i].data);
            end
        end
        acc_q.delete();
        tx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_fail++;
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail);
    end

    vec_t       vt[9];
    logic [7:0] msg[7];
    int         ei, ri, a2;

    initial begin
        // order bit i = 1 means the i-th accepted byte is a report byte.
        vt[0] = '{2, 2, 16'b1010,  4, 1'b1};
        vt[1] = '{1, 0, 16'b0,     1, 1'b0};
        vt[2] = '{0, 1, 16'b1,     1, 1'b0};
        vt[3] = '{1, 1, 16'b10,    2, 1'b0};
        vt[4] = '{1, 1, 16'b10,    2, 1'b0};
        vt[5] = '{2, 3, 16'b01110, 5, 1'b0};
        vt[6] = '{1, 2, 16'b011,   3, 1'b0};
        vt[7] = '{2, 1, 16'b001,   3, 1'b0};
        vt[8] = '{3, 0, 16'b000,   3, 1'b0};
        msg   = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h0D, 8'h0A};

        rst = 1'b0;
        tick(3);
        chk("rst_tx_start", bus.tx_start, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_e_ready", bus.e_ready, 1'b0);
        chk("rst_r_ready", bus.r_ready, 1'b0);
        chk("rst_abort", bus.abort, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick(1);

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < int'(vt[v].n_echo); k++) eq.push_back(8'(8'hE0 + k));
            for (int k = 0; k < int'(vt[v].n_rep); k++)
                rq.push_back({(vt[v].single || k == int'(vt[v].n_rep) - 1), 8'(8'hA0 + k)});
            ei = 0;
            ri = 0;
            for (int i = 0; i < int'(vt[v].n_tot); i++) begin
                if (vt[v].order[i]) begin exp_add(1'b1, 8'(8'hA0 + ri)); ri++; end
                else begin exp_add(1'b0, 8'(8'hE0 + ei)); ei++; end
            end
            wait_accepts(int'(vt[v].n_tot));
            check_seq($sformatf("vec%0d", v));
        end

        // Echo-only latency: start one cycle after accept, next accept right after busy falls.
        eq.push_back(8'h52);
        eq.push_back(8'h53);
        wait_accepts(2);
        if (acc_q.size() >= 2 && tx_q.size() >= 1) begin
            chk("lat_start", tx_q[0].cyc, acc_q[0].cyc + 1);
            chk("lat_next_accept", acc_q[1].cyc, acc_q[0].cyc + BUSY_LEN + 2);
        end else begin
            chk("lat_events", acc_q.size(), 2);
        end
        exp_add(1'b0, 8'h52);
        exp_add(1'b0, 8'h53);
        check_seq("echo_only");

        // Report packet holds the transmitter while echo waits.
        eq.push_back(8'h45);
        for (int k = 0; k < 7; k++) rq.push_back({(k == 6), msg[k]});
        for (int k = 0; k < 7; k++) exp_add(1'b1, msg[k]);
        exp_add(1'b0, 8'h45);
        wait_accepts(8);
        check_seq("report_pkt");

        // tx_busy held in IDLE: nothing may be accepted.
        busy_force = 1'b1;
        tick(2);
        eq.push_back(8'h11);
        rq.push_back({1'b1, 8'h22});
        tick(20);
        chk("busy_hold_noaccept", acc_q.size(), 0);
        busy_force = 1'b0;
        exp_add(1'b1, 8'h22);
        exp_add(1'b0, 8'h11);
        wait_accepts(2);
        check_seq("busy_hold");

        // Report stalls mid-packet with echo pending.
        for (int k = 0; k < 3; k++) rq.push_back({1'b0, 8'(8'hA0 + k)});
        begin
            int k;
            k = 0;
            while (acc_q.size() < 1 && k < 200) begin tick(1); k++; end
        end
        eq.push_back(8'h77);
        for (int k = 0; k < 3; k++) exp_add(1'b1, 8'(8'hA0 + k));
`ifdef UART_ARB_TIMEOUT_EN
        exp_add(1'b0, 8'h77);
        wait_accepts(4);
        chk("to_abort_count", abort_cnt, 1);
        chk("to_abort_grant", abort_grant, 2'b00);
        if (acc_q.size() >= 4) begin
            a2 = acc_q[2].cyc;
            chk("to_abort_cycle", abort_cyc, a2 + BUSY_LEN + 2 + int'(TO));
            chk("to_echo_after_abort", acc_q[3].cyc, abort_cyc);
        end
        check_seq("stall_timeout");
`else
        tick(40 + 3 * (BUSY_LEN + 4) + 80);
        chk("stall_echo_blocked", acc_q.size(), 3);
        chk("stall_no_abort", abort_cnt, 0);
        rq.push_back({1'b1, 8'hA3});
        exp_add(1'b1, 8'hA3);
        exp_add(1'b0, 8'h77);
        wait_accepts(5);
        check_seq("stall_locked");
`endif

        // Reset during WAIT_DONE, then first tie goes to echo.
        eq.push_back(8'h99);
        begin
            int k;
            k = 0;
            while (tx_q.size() < 1 && k < 200) begin tick(1); k++; end
        end
        tick(4);
        eq.push_back(8'h5A);
        rq.push_back({1'b1, 8'hC3});
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_grant", bus.grant, 2'b00);
        chk("mid_rst_tx_start", bus.tx_start, 1'b0);
        chk("mid_rst_tx_data", bus.tx_data, 8'h00);
        chk("mid_rst_e_ready", bus.e_ready, 1'b0);
        chk("mid_rst_r_ready", bus.r_ready, 1'b0);
        tick(1);
        chk("rst_hold_e_ready", bus.e_ready, 1'b0);
        chk("rst_hold_r_ready", bus.r_ready, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        exp_add(1'b0, 8'h99);
        exp_add(1'b0, 8'h5A);
        exp_add(1'b1, 8'hC3);
        wait_accepts(3);
        check_seq("mid_reset");

        chk("ready_exclusive", excl_bad, 0);
        chk("grant_held_in_packet", grant_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
